// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED mode controller: mode encoding,
// per-mode seed patterns, dim-level type and the per-tick pattern update.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_SHIFT = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    typedef logic [1:0] dim_t;

    localparam logic [3:0] SEED_OFF   = 4'b0000;
    localparam logic [3:0] SEED_COUNT = 4'b0000;
    localparam logic [3:0] SEED_SHIFT = 4'b0001;
    localparam logic [3:0] SEED_BLINK = 4'b1111;

    localparam dim_t DIM_RESET = 2'd3;

    localparam int BTN_MODE  = 0;
    localparam int BTN_PAUSE = 1;
    localparam int BTN_DIM   = 2;

    function automatic logic [3:0] mode_seed(input mode_e m);
        logic [3:0] seed;
        case (m)
            MODE_COUNT: seed = SEED_COUNT;
            MODE_SHIFT: seed = SEED_SHIFT;
            MODE_BLINK: seed = SEED_BLINK;
            default:    seed = SEED_OFF;
        endcase
        return seed;
    endfunction

    // Pattern after one tick; OFF forces the pattern dark whatever it held.
    function automatic logic [3:0] pattern_step(input mode_e m, input logic [3:0] p);
        logic [3:0] nxt;
        case (m)
            MODE_COUNT: nxt = p + 4'd1;
            MODE_SHIFT: nxt = {p[2:0], p[3]};
            MODE_BLINK: nxt = ~p;
            default:    nxt = SEED_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, debounce counter and a one-cycle
// press pulse issued the cycle after an accepted 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          accepted;
    logic          accepted_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a        <= 1'b0;
            sync_b        <= 1'b0;
            accepted      <= 1'b0;
            accepted_prev <= 1'b0;
            cnt           <= '0;
            press         <= 1'b0;
        end else begin
            sync_a        <= raw;
            sync_b        <= sync_a;
            accepted_prev <= accepted;
            press         <= accepted & ~accepted_prev;
            // Any cycle agreeing with the accepted state restarts the count.
            if (sync_b == accepted) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                accepted <= sync_b;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED pattern controller: mode/pause/dim buttons drive a stepped LED pattern.
// Define LED_MODE_CTRL_PWM_EN to add the btn[2] dim level and PWM gating.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_CYCLES     = 8
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       paused
);

    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_CYCLES - 1);

    logic [2:0]    press;
    logic          mode_press;
    logic          pause_press;
    mode_e         state;
    mode_e         state_next;
    logic [3:0]    seed_next;
    logic [3:0]    pattern;
    logic          paused_q;
    logic [PW-1:0] pre_cnt;
    logic          tick;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .sclk (sclk),
            .rst_n(rst_n),
            .raw  (btn[i]),
            .press(press[i])
        );
    end

    assign mode_press  = press[BTN_MODE];
    assign pause_press = press[BTN_PAUSE];
    assign tick        = (pre_cnt == PRE_LAST);

    // Mode FSM: state register
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MODE_OFF;
        end else begin
            state <= state_next;
        end
    end

    // Mode FSM: next state
    always_comb begin
        state_next = state;
        if (mode_press) begin
            case (state)
                MODE_OFF:   state_next = MODE_COUNT;
                MODE_COUNT: state_next = MODE_SHIFT;
                MODE_SHIFT: state_next = MODE_BLINK;
                default:    state_next = MODE_OFF;
            endcase
        end
    end

    // Mode FSM: outputs
    always_comb begin
        mode      = state;
        seed_next = mode_seed(state_next);
    end

    // A mode change outranks both a coincident pause toggle and a tick.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            pattern  <= SEED_OFF;
            paused_q <= 1'b0;
            pre_cnt  <= '0;
        end else if (mode_press) begin
            pattern  <= seed_next;
            paused_q <= 1'b0;
            pre_cnt  <= '0;
        end else begin
            if (pause_press) begin
                paused_q <= ~paused_q;
            end
            if (!paused_q) begin
                pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
                if (tick) begin
                    pattern <= pattern_step(state, pattern);
                end
            end
        end
    end

    assign paused = paused_q;

`ifdef LED_MODE_CTRL_PWM_EN
    dim_t       dim;
    logic [1:0] pwm_cnt;
    logic [3:0] led_q;
    logic       unused_btn;

    // dim=3 keeps the gate open every cycle; dim=0 opens it one cycle in four.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            dim     <= DIM_RESET;
            pwm_cnt <= 2'd0;
            led_q   <= 4'b0000;
        end else begin
            pwm_cnt <= pwm_cnt + 2'd1;
            if (press[BTN_DIM]) begin
                dim <= dim - 2'd1;
            end
            led_q <= pattern & {4{pwm_cnt <= dim}};
        end
    end

    assign led        = led_q;
    assign unused_btn = btn[3];
`else
    logic [1:0] unused_btn;

    assign led        = pattern;
    assign unused_btn = {btn[3], press[BTN_DIM]};
`endif

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl (DEBOUNCE_CYCLES=4, STEP_CYCLES=8).
// Button timing: a press driven just after edge k takes effect at edge k+8.
module tb_led_mode_ctrl;

    logic       sclk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] led;
    logic [1:0] mode;
    logic       paused;

    int checks   = 0;
    int failures = 0;
    int on_cnt   = 0;
    int off_cnt  = 0;

    logic [3:0] exp_q[$];

    led_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES    (8)
    ) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .btn   (btn),
        .led   (led),
        .mode  (mode),
        .paused(paused)
    );

    always #5 sclk = ~sclk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press_mode();
        btn[0] = 1'b1;
        step(10);
        btn[0] = 1'b0;
        step(8);
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 4'b0000;
        step(3);
        check("reset_led",    8'(led),    8'h0);
        check("reset_mode",   8'(mode),   8'h0);
        check("reset_paused", 8'(paused), 8'h0);
        rst_n = 1'b1;

        // 3-cycle glitch never reaches the accept threshold
        btn = 4'b0001;
        step(3);
        btn = 4'b0000;
        step(12);
        check("glitch_mode", 8'(mode), 8'h0);
        check("glitch_led",  8'(led),  8'h0);

        // OFF -> COUNT, then 16 ticks to wrap
        btn = 4'b0001;
        step(7);
        check("count_pre_mode", 8'(mode), 8'h0);
        step(1);
        check("count_mode", 8'(mode), 8'h1);
        check("count_seed", 8'(led),  8'h0);
        step(2);
        btn = 4'b0000;
        step(5);
        check("count_hold",  8'(led), 8'h0);
        step(1);
        check("count_step1", 8'(led), 8'h1);
        step(112);
        check("count_step15", 8'(led), 8'hF);
        step(8);
        check("count_wrap",   8'(led), 8'h0);

        // COUNT -> SHIFT, five ticks
        exp_q = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
        btn = 4'b0001;
        step(8);
        check("shift_mode", 8'(mode), 8'h2);
        check("shift_seed", 8'(led),  8'(exp_q.pop_front()));
        step(2);
        btn = 4'b0000;
        step(6);
        check("shift_led", 8'(led), 8'(exp_q.pop_front()));
        while (exp_q.size() > 0) begin
            step(8);
            check("shift_led", 8'(led), 8'(exp_q.pop_front()));
        end

        // SHIFT -> BLINK, pause landing on a tick edge, then resume
        btn = 4'b0001;
        step(8);
        check("blink_mode", 8'(mode), 8'h3);
        check("blink_seed", 8'(led),  8'hF);
        step(2);
        btn = 4'b0000;
        step(6);
        check("blink_toggle", 8'(led), 8'h0);
        btn = 4'b0010;
        step(8);
        check("pause_on",  8'(paused), 8'h1);
        check("pause_led", 8'(led),    8'hF);
        step(2);
        btn = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step(10);
            check("pause_hold", 8'(led), 8'hF);
        end
        check("pause_still", 8'(paused), 8'h1);
        btn = 4'b0010;
        step(8);
        check("resume_paused", 8'(paused), 8'h0);
        check("resume_led",    8'(led),    8'hF);
        step(2);
        btn = 4'b0000;
        step(5);
        check("resume_wait",   8'(led), 8'hF);
        step(1);
        check("resume_toggle", 8'(led), 8'h0);

        // Mode and pause pressed together: mode wins, BLINK -> OFF
        btn = 4'b0011;
        step(8);
        check("both_mode",   8'(mode),   8'h0);
        check("both_paused", 8'(paused), 8'h0);
        check("both_led",    8'(led),    8'h0);
        step(2);
        btn = 4'b0000;
        step(8);

        // Back to BLINK, frozen at 1111 by a pause one cycle after the mode change
        press_mode();
        press_mode();
        check("dim_pre_mode", 8'(mode), 8'h2);
        btn = 4'b0001;
        step(1);
        btn = 4'b0011;
        step(7);
        check("dim_mode", 8'(mode), 8'h3);
        check("dim_seed", 8'(led),  8'hF);
        step(1);
        check("dim_paused", 8'(paused), 8'h1);
        step(1);
        btn = 4'b0000;
        step(8);
        for (int i = 0; i < 2; i++) begin
            btn = 4'b0100;
            step(10);
            btn = 4'b0000;
            step(8);
        end
`ifdef LED_MODE_CTRL_PWM_EN
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (led == 4'hF) on_cnt++;
            if (led == 4'h0) off_cnt++;
        end
        check("pwm_on_cycles",  8'(on_cnt),  8'd2);
        check("pwm_off_cycles", 8'(off_cnt), 8'd2);
`else
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("dim_ignored", 8'(led), 8'hF);
        end
`endif

        // Reset in the middle of a press: async clear, press discarded
        btn = 4'b0001;
        step(5);
        rst_n = 1'b0;
        #1;
        check("rst_async_mode",   8'(mode),   8'h0);
        check("rst_async_led",    8'(led),    8'h0);
        check("rst_async_paused", 8'(paused), 8'h0);
        step(2);
        btn = 4'b0000;
        step(2);
        rst_n = 1'b1;
        step(20);
        check("rst_no_press_mode", 8'(mode), 8'h0);
        check("rst_no_press_led",  8'(led),  8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronised cycles before a button state is accepted (range 2..2^20).
REQ-002 The block SHALL have parameter STEP_CYCLES, default 8, meaning sclk cycles per pattern step (range 2..2^26).
REQ-003 The block SHALL have port sclk, input, 1 bit: sole clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port btn, input, 4 bits: raw asynchronous push-buttons, active-high. Bit 0 is mode, bit 1 is pause, bit 2 is dim, bit 3 is unused.
REQ-006 The block SHALL have port led, output, 4 bits: LED drive, registered.
REQ-007 The block SHALL have port mode, output, 2 bits: current mode (OFF=0, COUNT=1, SHIFT=2, BLINK=3).
REQ-008 The block SHALL have port paused, output, 1 bit: high while stepping is frozen.

Function
REQ-009 Each of btn[2:0] SHALL pass through a 2-flop synchroniser and a debounce counter. The counter clears whenever the synced value equals the accepted state; the accepted state flips after DEBOUNCE_CYCLES consecutive differing cycles.
REQ-010 A one-cycle press pulse SHALL assert on the cycle after an accepted 0->1 transition. Total latency from raw rise is 2 + DEBOUNCE_CYCLES + 1 cycles. Releases produce no pulse.
REQ-011 A prescaler SHALL count 0..STEP_CYCLES-1 and wrap. tick is high when the count equals STEP_CYCLES-1. The prescaler does not advance while paused=1.
REQ-012 Mode SHALL advance OFF->COUNT->SHIFT->BLINK->OFF on each btn[0] press pulse.
REQ-013 On the edge that applies a mode change, the block SHALL clear the prescaler and paused, and load led with the mode's seed: OFF 0000, COUNT 0000, SHIFT 0001, BLINK 1111.
REQ-014 On a tick edge in COUNT, led SHALL become led+1 modulo 16 (1111->0000).
REQ-015 On a tick edge in SHIFT, led SHALL rotate left (1000->0001).
REQ-016 On a tick edge in BLINK, led SHALL invert (1111<->0000).
REQ-017 In OFF, led SHALL stay 0000 regardless of tick.
REQ-018 A btn[1] press pulse SHALL toggle paused. While paused, led and the prescaler SHALL hold.
REQ-019 If btn[0] and btn[1] pulses occur in the same cycle, the mode change SHALL win and paused SHALL end at 0.
REQ-020 If a mode pulse coincides with a tick, the seed load SHALL win and the tick SHALL be discarded.

Reset
REQ-021 While rst_n=0, the block SHALL asynchronously force: led=0000, mode=OFF, paused=0, prescaler=0, synchronisers and accepted states=0, debounce counters=0, dim level=3.
REQ-022 Reset deassertion SHALL be usable synchronously to sclk. The first tick SHALL occur STEP_CYCLES cycles after release.
REQ-023 A reset mid-press SHALL discard the press. No pulse occurs unless the button is re-accepted after release from reset.

Configuration
REQ-024 With macro LED_MODE_CTRL_PWM_EN defined:
- A 2-bit dim level SHALL decrement on each btn[2] press (3->2->1->0->3).
- A free-running 2-bit PWM counter SHALL gate the LEDs: led = pattern & {4{pwm_cnt <= dim}}, giving 25/50/75/100% duty.
- The PWM counter resets to 0.
REQ-025 Without LED_MODE_CTRL_PWM_EN, the block SHALL ignore btn[2], omit the dim and PWM logic, and drive led directly from the pattern register.

Structure
REQ-026 Package led_ctrl_pkg SHALL hold the mode_e enum (2-bit), the per-mode seed constants, and the dim-level type.
REQ-027 Sub-module btn_debounce SHALL contain the synchroniser, the debounce counter and the press-pulse logic for one button (parameter DEBOUNCE_CYCLES). It is instantiated three times.

Verification
REQ-028 The bench SHALL cover: reset, then btn[0] high for 10 cycles -> mode=1 at cycle 8 after the rise, led=0000, then led=0001 after 8 more cycles, and 1111->0000 wrap at step 16.
REQ-029 The bench SHALL cover: a btn[0] glitch of 3 cycles (< 2+DEBOUNCE_CYCLES) -> no pulse, mode unchanged.
REQ-030 The bench SHALL cover: mode SHIFT for 5 ticks -> led sequence 0001,0010,0100,1000,0001,0010.
REQ-031 The bench SHALL cover: a btn[1] press in BLINK -> paused=1 and led frozen for 40 cycles; a second press -> resumes, with the next toggle 8 cycles later.
REQ-032 The bench SHALL cover: btn[0] and btn[1] pressed together while paused=0 -> mode advances, paused=0.
REQ-033 The bench SHALL cover: with PWM_EN, two btn[2] presses (dim=1) in BLINK while led pattern=1111 -> led high 2 of every 4 cycles; without PWM_EN -> led constantly 1111.
